// File: rtl/mux_share_arbiter_if.sv
// Handshake and data bundle between the two requesters and the shared mux.
interface mux_share_arbiter_if #(
    parameter int DATA_W = 1
);
    logic [1:0]        req;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [1:0]        grant;
    logic              sel;
    logic [DATA_W-1:0] m;
    logic              valid;

    modport master (
        output req, x, y,
        input  grant, sel, m, valid
    );

    modport slave (
        input  req, x, y,
        output grant, sel, m, valid
    );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 2:1 mux with a hold cap under contention.
// Requester 0 owns x, requester 1 owns y; m/valid trail grant by one cycle.
//
// state | meaning
// IDLE  | nobody owns the path; grant=00, sel keeps its last value
// GNT0  | requester 0 owns the path; grant=01, sel=0
// GNT1  | requester 1 owns the path; grant=10, sel=1
module mux_share_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    mux_share_arbiter_if.slave   bus
);

    localparam int              CNT_W    = 8;
    localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  hold_cnt, hold_nxt;
    logic              last, last_nxt;
    logic              sel_q;
    logic [DATA_W-1:0] m_q;
    logic              valid_q;
    logic [1:0]        grant;

    // Grant is a straight decode of the registered state.
    assign grant     = {state == GNT1, state == GNT0};
    assign bus.grant = grant;
    assign bus.sel   = sel_q;
    assign bus.m     = m_q;
    assign bus.valid = valid_q;

    // State, hold counter and round-robin pointer registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
        end
    end

    // Next-state: tie goes to whoever did not win last; the holder is
    // pushed back to IDLE once it has used its quota while the other waits.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (bus.req == 2'b01 || (bus.req == 2'b11 && last)) begin
                    state_nxt = GNT0;
                    hold_nxt  = '0;
                    last_nxt  = 1'b0;
                end else if (bus.req == 2'b10 || (bus.req == 2'b11 && !last)) begin
                    state_nxt = GNT1;
                    hold_nxt  = '0;
                    last_nxt  = 1'b1;
                end
            end
            GNT0: begin
                if (!bus.req[0]) begin
                    state_nxt = IDLE;
                end else if (bus.req[1] && hold_cnt == HOLD_TOP) begin
                    state_nxt = IDLE;
                end else if (hold_cnt != HOLD_TOP) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            GNT1: begin
                if (!bus.req[1]) begin
                    state_nxt = IDLE;
                end else if (bus.req[0] && hold_cnt == HOLD_TOP) begin
                    state_nxt = IDLE;
                end else if (hold_cnt != HOLD_TOP) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Select follows the granted owner and is left alone while idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel_q <= 1'b0;
        end else if (state_nxt == GNT0) begin
            sel_q <= 1'b0;
        end else if (state_nxt == GNT1) begin
            sel_q <= 1'b1;
        end
    end

    // Output register: capture the granted input, hold m when nobody owns the path.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= |grant;
            if (|grant) begin
                m_q <= sel_q ? bus.y : bus.x;
            end
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter with an ownership-level reference model.
`timescale 1ns/100ps
module tb_mux_share_arbiter;

    localparam int DATA_W   = 1;
    localparam int MAX_HOLD = 8;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mux_share_arbiter_if #(.DATA_W(DATA_W)) bus();

    mux_share_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #10 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the path, for how many cycles, who won last.
    int                owner    = -1;
    int                held     = 0;
    int                last_win = 1;
    logic              exp_sel  = 1'b0;
    logic [DATA_W-1:0] exp_m    = '0;
    logic              exp_v    = 1'b0;

    always @(posedge clock or negedge resetn) begin
        int nxt;
        if (!resetn) begin
            owner = -1; held = 0; last_win = 1;
            exp_sel = 1'b0; exp_m = '0; exp_v = 1'b0;
        end else begin
            exp_v = (owner >= 0);
            if (owner >= 0) exp_m = (owner == 1) ? bus.y : bus.x;
            nxt = owner;
            if (owner < 0) begin
                if (bus.req == 2'b01)      nxt = 0;
                else if (bus.req == 2'b10) nxt = 1;
                else if (bus.req == 2'b11) nxt = (last_win == 1) ? 0 : 1;
                if (nxt >= 0) begin
                    last_win = nxt;
                    held     = 1;
                end
            end else if (!bus.req[owner]) begin
                nxt = -1;
            end else if (bus.req[1-owner] && held >= MAX_HOLD) begin
                nxt = -1;
            end else begin
                held++;
            end
            owner = nxt;
            if (owner == 0) exp_sel = 1'b0;
            else if (owner == 1) exp_sel = 1'b1;
        end
    end

    // Every-cycle comparison against the model, plus grant-shape invariants.
    logic [1:0] prev_grant = 2'b00;
    always @(negedge clock) begin
        logic [1:0] eg;
        eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        chk("model_grant", 32'(bus.grant), 32'(eg));
        chk("model_sel",   32'(bus.sel),   32'(exp_sel));
        chk("model_m",     32'(bus.m),     32'(exp_m));
        chk("model_valid", 32'(bus.valid), 32'(exp_v));
        chk("grant_not_11", 32'(bus.grant == 2'b11), 32'd0);
        chk("no_direct_swap",
            32'((prev_grant == 2'b01 && bus.grant == 2'b10) ||
                (prev_grant == 2'b10 && bus.grant == 2'b01)), 32'd0);
        prev_grant = bus.grant;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        int n;
        bus.req = 2'b00; bus.x = '0; bus.y = '0;

        // reset held, then idle with no requests
        repeat (3) @(posedge clock);
        #2 resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("idle_grant", 32'(bus.grant), 32'd0);
            chk("idle_valid", 32'(bus.valid), 32'd0);
            chk("idle_m",     32'(bus.m),     32'd0);
        end

        // single requester 1, y = 1,0,1 during the grant
        bus.req = 2'b10; bus.y = 1'b1;
        tick(1);
        chk("single_grant", 32'(bus.grant), 32'b10);
        chk("single_sel",   32'(bus.sel),   32'd1);
        tick(1);
        chk("single_m0", 32'(bus.m), 32'd1);
        chk("single_v0", 32'(bus.valid), 32'd1);
        bus.y = 1'b0;
        tick(1);
        chk("single_m1", 32'(bus.m), 32'd0);
        bus.y = 1'b1;
        tick(1);
        chk("single_m2", 32'(bus.m), 32'd1);
        bus.req = 2'b00;
        tick(1);
        chk("single_rel_grant", 32'(bus.grant), 32'd0);
        chk("single_rel_valid", 32'(bus.valid), 32'd1);
        tick(1);
        chk("single_drop_valid", 32'(bus.valid), 32'd0);
        chk("single_hold_m",     32'(bus.m),     32'd1);

        // tie: requester 0 first, releases after 3 cycles, then requester 1
        bus.req = 2'b11;
        tick(1);
        chk("tie_first", 32'(bus.grant), 32'b01);
        tick(2);
        bus.req = 2'b10;
        tick(1);
        chk("tie_turnaround", 32'(bus.grant), 32'd0);
        tick(1);
        chk("tie_second", 32'(bus.grant), 32'b10);
        bus.req = 2'b00;
        tick(3);

        // preemption: requester 1 joins two cycles into requester 0's grant
        bus.req = 2'b01;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            bus.x = k[0];
            if (bus.grant == 2'b01) n++;
            else if (n > 0) break;
            if (k == 1) bus.req = 2'b11;
        end
        chk("preempt_len", 32'(n), 32'd8);
        chk("preempt_gap", 32'(bus.grant), 32'd0);
        tick(1);
        chk("preempt_next", 32'(bus.grant), 32'b10);
        bus.req = 2'b00;
        tick(3);

        // lone requester keeps the path; saturated counter preempts at once
        bus.req = 2'b01;
        tick(1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            bus.x = k[1];
            bus.y = ~k[0];
            tick(1);
            if (bus.grant == 2'b01) n++;
        end
        chk("alone_len", 32'(n), 32'd40);
        bus.req = 2'b11;
        tick(1);
        chk("sat_preempt", 32'(bus.grant), 32'd0);
        tick(1);
        chk("sat_next", 32'(bus.grant), 32'b10);
        bus.y = 1'b1;
        tick(2);

        // async reset pulsed between edges while requester 1 holds the path
        chk("pre_rst_grant", 32'(bus.grant), 32'b10);
        chk("pre_rst_m",     32'(bus.m),     32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_m",     32'(bus.m),     32'd0);
        #1 resetn = 1'b1;
        bus.req = 2'b11;
        tick(1);
        chk("rst_tie", 32'(bus.grant), 32'b01);
        tick(2);
        bus.req = 2'b00;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached t=%0t", $time);
        $fatal(1);
    end

endmodule
